apb_regbank: RTL and testbench
==============================

// Module: apb_regbank
// PURPOSE
//  Parametrised APB slave register bank for the rotate engine and later DMA/core blocks.
//  Generalises the fixed rotate register map: N x 32-bit word registers, per-register RO / self-clear typing,
//  byte strobes, programmable wait states, PSLVERR. Sits between the APB bus and the core control/status nets.
// PARAMETERS
//  NUM_REGS     16       number of 32-bit registers; register i at byte address 4*i
//  ADDR_W       8        I_PADDR width; requires 4*NUM_REGS <= 2**ADDR_W
//  WAIT_STATES  0        extra access-phase cycles with O_PREADY low before completion (0..15)
//  RO_MASK      16'h0    bit i=1: register i read-only; reads return the I_HW_FLAT slice
//  SC_MASK      16'h0    bit i=1: register i self-clearing (start/reset/clear strobes); reads return 0
// PORTS
//  I_PCLK       in   1              the only clock; all logic on its rising edge
//  I_PRESET     in   1              synchronous, active-high reset
//  I_PSEL       in   1              APB select
//  I_PENABLE    in   1              APB enable (access phase)
//  I_PWRITE     in   1              1=write, 0=read
//  I_PADDR      in   ADDR_W         byte address
//  I_PWDATA     in   32             write data
//  I_PSTRB      in   4              byte-lane write strobes
//  O_PRDATA     out  32             read data, valid while O_PREADY=1
//  O_PREADY     out  1              transfer completion
//  O_PSLVERR    out  1              error response, valid while O_PREADY=1
//  O_REG_FLAT   out  32*NUM_REGS    stored register contents to core; register i = bits [32*i+31:32*i]
//  I_HW_FLAT    in   32*NUM_REGS    core status values for RO registers (non-RO slices ignored)
//  O_WR_PULSE   out  NUM_REGS       one-cycle pulse per committed register write
// BEHAVIOUR
//  Reset: O_PRDATA=0, O_PREADY=0, O_PSLVERR=0, O_REG_FLAT=0, O_WR_PULSE=0, FSM=IDLE, wait counter=0.
//  FSM IDLE: on PSEL&!PENABLE (setup) -> ACCESS, cnt<=0, O_PREADY<=(WAIT_STATES==0).
//  FSM ACCESS, O_PREADY=0: cnt<=cnt+1; O_PREADY<=(cnt+1==WAIT_STATES).
//  FSM ACCESS, O_PREADY=1 & PSEL & PENABLE: transfer completes at this edge; O_PREADY<=0, O_PSLVERR<=0 -> IDLE.
//  PSEL low in ACCESS (abort): -> IDLE, O_PREADY<=0, no write, no pulse.
//  Latency: O_PREADY high in access cycle 1+WAIT_STATES; WAIT_STATES=0 gives the zero-wait APB transfer.
//  O_PRDATA and O_PSLVERR load on the same edge that raises O_PREADY; O_PRDATA holds afterwards.
//  Error (O_PSLVERR=1): index PADDR[ADDR_W-1:2] >= NUM_REGS, PADDR[1:0]!=0, or write to a RO register.
//  An errored transfer writes nothing, pulses nothing; errored reads return O_PRDATA=0.
//  Write commit on the completion edge: each byte lane b with PSTRB[b]=1 updated; PSTRB=0 commits with no change
//  but still pulses O_WR_PULSE[i] in the following cycle.
//  SC register: written bits appear on O_REG_FLAT for exactly one cycle, then return to 0.
//  Reads: RO -> I_HW_FLAT slice sampled at the O_PREADY-raising edge; SC -> 0; others -> stored value.
//  Back-to-back: a new setup in the cycle after completion is accepted with no idle cycle.
//  Reset mid-transfer: transfer dropped, all state to reset values, nothing written.
// CONFIGURATION
//  APB_REGBANK_INTR_EN defined: adds register NUM_REGS (INTR_STAT, W1C) and NUM_REGS+1 (INTR_EN, RW),
//   input I_INTR_SET[7:0] (sticky set) and output O_INTR = |(INTR_STAT[7:0] & INTR_EN[7:0]), registered.
//   Set and W1C clear of the same bit in the same cycle: set wins. Index range check uses NUM_REGS+2.
//  Not defined: no extra registers or ports; index >= NUM_REGS errors as above.
// TESTING
//  WAIT_STATES=0, write 0xDEADBEEF to 0x04, PSTRB=4'hF -> PREADY in first access cycle; O_REG_FLAT[63:32]=DEADBEEF, O_WR_PULSE[1] one cycle.
//  WAIT_STATES=3, read 0x04 -> PREADY low 3 access cycles, high 4th; PRDATA=DEADBEEF, PSLVERR=0.
//  Write 0x11223344 to 0x04 with PSTRB=4'b0101 -> register 1 reads 0xDE22BE44.
//  Write to RO reg 2 (RO_MASK=16'h4), addr 0x40 (NUM_REGS=16), addr 0x05 -> PSLVERR=1, no state change, PRDATA=0.
//  SC reg 3 (SC_MASK=16'h8) write 0x1 -> O_REG_FLAT[96]=1 one cycle only; read 0x0C -> 0.
//  I_PRESET asserted during wait states of a write -> PREADY=0, target register stays 0; INTR_EN build: set+W1C same cycle keeps bit=1.

Source files
------------

// File: rtl/apb_regbank_if.sv
// APB bus bundle for apb_regbank: setup/access handshake, address, data and response.
interface apb_regbank_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [3:0]        pstrb;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_regbank.sv
// Parametrised APB slave register bank: NUM_REGS word registers with per-register read-only
// (hardware status) and self-clearing (strobe) typing, byte-lane writes, programmable wait
// states and PSLVERR on bad index, misaligned address or write to a read-only register.
// Optional feature macro: APB_REGBANK_INTR_EN adds INTR_STAT (W1C, index NUM_REGS) and
// INTR_EN (RW, index NUM_REGS+1) with a registered interrupt output.
module apb_regbank #(
    parameter int unsigned         NUM_REGS    = 16,
    parameter int unsigned         ADDR_W      = 8,
    parameter int unsigned         WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
    parameter logic [NUM_REGS-1:0] SC_MASK     = '0
) (
    input  logic                     I_PCLK,
    input  logic                     I_PRESET,
    apb_regbank_if.slave             bus,
    output logic [32*NUM_REGS-1:0]   O_REG_FLAT,
    input  logic [32*NUM_REGS-1:0]   I_HW_FLAT,
    output logic [NUM_REGS-1:0]      O_WR_PULSE
`ifdef APB_REGBANK_INTR_EN
    ,
    input  logic [7:0]               I_INTR_SET,
    output logic                     O_INTR
`endif
);

    localparam int unsigned IDX_W = ADDR_W - 2;
`ifdef APB_REGBANK_INTR_EN
    localparam int unsigned NUM_IDX = NUM_REGS + 2;
`else
    localparam int unsigned NUM_IDX = NUM_REGS;
`endif

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        pready_q, pready_d;
    logic        pslverr_q, pslverr_d;
    logic [31:0] prdata_q, prdata_d;
    logic        raise;
    logic        commit;

    logic [31:0]         regs_q [NUM_REGS];
    logic [31:0]         regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

    logic [IDX_W-1:0] idx;
    logic             idx_ok;
    logic             ro_hit;
    logic             acc_err;
    logic [31:0]      rd_val;

`ifdef APB_REGBANK_INTR_EN
    logic [7:0] intr_stat_q, intr_stat_d;
    logic [7:0] intr_en_q, intr_en_d;
    logic       intr_q;
`endif

    assign idx = bus.paddr[ADDR_W-1:2];

    // Address decode, error classification and read-data selection for the current address.
    always_comb begin
        idx_ok = (32'(idx) < NUM_IDX);
        ro_hit = 1'b0;
        rd_val = 32'h0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(idx) == i) begin
                ro_hit = RO_MASK[i];
                if (RO_MASK[i]) begin
                    rd_val = I_HW_FLAT[32*i +: 32];
                end else if (SC_MASK[i]) begin
                    rd_val = 32'h0;
                end else begin
                    rd_val = regs_q[i];
                end
            end
        end
`ifdef APB_REGBANK_INTR_EN
        if (32'(idx) == NUM_REGS) begin
            rd_val = {24'h0, intr_stat_q};
        end
        if (32'(idx) == NUM_REGS + 1) begin
            rd_val = {24'h0, intr_en_q};
        end
`endif
        acc_err = !idx_ok || (bus.paddr[1:0] != 2'b00) || (bus.pwrite && ro_hit);
    end

    // FSM next state, wait counting and response capture on the PREADY-raising edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
        raise     = 1'b0;
        commit    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.psel && !bus.penable) begin
                    state_d = StAccess;
                    cnt_d   = 4'd0;
                    raise   = (WAIT_STATES == 0);
                end
            end
            StAccess: begin
                if (!bus.psel) begin
                    // Abort: drop the transfer without touching the register file.
                    state_d   = StIdle;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                end else if (!pready_q) begin
                    cnt_d = cnt_q + 4'd1;
                    raise = ({1'b0, cnt_q} + 5'd1 == 5'(WAIT_STATES));
                end else if (bus.penable) begin
                    commit    = bus.pwrite && !pslverr_q;
                    state_d   = StIdle;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (raise) begin
            pready_d  = 1'b1;
            pslverr_d = acc_err;
            prdata_d  = acc_err ? 32'h0 : rd_val;
        end
    end

    // FSM and bus response registers.
    always_ff @(posedge I_PCLK) begin
        if (I_PRESET) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    // Register file next state: byte-lane merge on commit, self-clearing registers fall back to 0.
    always_comb begin
        wr_pulse_d = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = SC_MASK[i] ? 32'h0 : regs_q[i];
            if (commit && (32'(idx) == i)) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (bus.pstrb[b]) begin
                        regs_d[i][8*b +: 8] = bus.pwdata[8*b +: 8];
                    end
                end
                wr_pulse_d[i] = 1'b1;
            end
        end
    end

    // Register file and write pulse storage.
    always_ff @(posedge I_PCLK) begin
        if (I_PRESET) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 32'h0;
            end
            wr_pulse_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            wr_pulse_q <= wr_pulse_d;
        end
    end

`ifdef APB_REGBANK_INTR_EN
    // Interrupt status/enable next state; a hardware set beats a same-cycle W1C clear.
    always_comb begin
        intr_stat_d = intr_stat_q;
        intr_en_d   = intr_en_q;
        if (commit && bus.pstrb[0]) begin
            if (32'(idx) == NUM_REGS) begin
                intr_stat_d = intr_stat_q & ~bus.pwdata[7:0];
            end
            if (32'(idx) == NUM_REGS + 1) begin
                intr_en_d = bus.pwdata[7:0];
            end
        end
        intr_stat_d = intr_stat_d | I_INTR_SET;
    end

    // Interrupt registers and registered interrupt output.
    always_ff @(posedge I_PCLK) begin
        if (I_PRESET) begin
            intr_stat_q <= 8'h0;
            intr_en_q   <= 8'h0;
            intr_q      <= 1'b0;
        end else begin
            intr_stat_q <= intr_stat_d;
            intr_en_q   <= intr_en_d;
            intr_q      <= |(intr_stat_q & intr_en_q);
        end
    end

    assign O_INTR = intr_q;
`endif

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign O_REG_FLAT[32*g +: 32] = regs_q[g];
    end

    assign O_WR_PULSE  = wr_pulse_q;
    assign bus.prdata  = prdata_q;
    assign bus.pready  = pready_q;
    assign bus.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_regbank.sv
// Directed bench for apb_regbank: a zero-wait instance and a three-wait instance share the
// bus lines (separate selects); table vectors plus hand sequences for multi-cycle cases.
module tb_apb_regbank;

    logic         clk;
    logic         rst;
    logic         psel0, psel1, penable, pwrite;
    logic [7:0]   paddr;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;
    logic [511:0] flat0, flat1, hw_flat;
    logic [15:0]  pulse0, pulse1;
`ifdef APB_REGBANK_INTR_EN
    logic         intr0, intr1;
`endif

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    bit          cur = 1'b0;

    apb_regbank_if #(.ADDR_W(8)) if0 ();
    apb_regbank_if #(.ADDR_W(8)) if1 ();

    assign if0.psel = psel0;   assign if1.psel = psel1;
    assign if0.penable = penable; assign if1.penable = penable;
    assign if0.pwrite = pwrite;   assign if1.pwrite = pwrite;
    assign if0.paddr = paddr;     assign if1.paddr = paddr;
    assign if0.pwdata = pwdata;   assign if1.pwdata = pwdata;
    assign if0.pstrb = pstrb;     assign if1.pstrb = pstrb;

    apb_regbank #(
        .NUM_REGS(16), .ADDR_W(8), .WAIT_STATES(0), .RO_MASK(16'h0004), .SC_MASK(16'h0008)
    ) dut0 (
        .I_PCLK(clk), .I_PRESET(rst), .bus(if0.slave),
        .O_REG_FLAT(flat0), .I_HW_FLAT(hw_flat), .O_WR_PULSE(pulse0)
`ifdef APB_REGBANK_INTR_EN
        , .I_INTR_SET(8'h0), .O_INTR(intr0)
`endif
    );

    apb_regbank #(
        .NUM_REGS(16), .ADDR_W(8), .WAIT_STATES(3), .RO_MASK(16'h0004), .SC_MASK(16'h0008)
    ) dut1 (
        .I_PCLK(clk), .I_PRESET(rst), .bus(if1.slave),
        .O_REG_FLAT(flat1), .I_HW_FLAT(hw_flat), .O_WR_PULSE(pulse1)
`ifdef APB_REGBANK_INTR_EN
        , .I_INTR_SET(8'h0), .O_INTR(intr1)
`endif
    );

    logic         cur_pready, cur_pslverr;
    logic [31:0]  cur_prdata;
    logic [15:0]  cur_pulse;
    logic [511:0] cur_flat;
    assign cur_pready  = cur ? if1.pready  : if0.pready;
    assign cur_pslverr = cur ? if1.pslverr : if0.pslverr;
    assign cur_prdata  = cur ? if1.prdata  : if0.prdata;
    assign cur_pulse   = cur ? pulse1 : pulse0;
    assign cur_flat    = cur ? flat1  : flat0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Full transfer with one idle cycle before it; returns response and post-completion snapshots.
    task automatic xfer(input bit which, input bit wr, input logic [7:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        output logic [31:0] rd, output logic err, output int unsigned waits,
                        output logic [15:0] p1, output logic [15:0] p2,
                        output logic [511:0] f1, output logic [511:0] f2);
        cur = which;
        @(negedge clk);
        if (which) psel1 = 1'b1; else psel0 = 1'b1;
        penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        @(negedge clk);
        penable = 1'b1;
        waits = 0;
        while (!cur_pready && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        if (!cur_pready) begin
            n_tests++;
            n_fail++;
            $display("FAIL pready timeout: got 0 expected 1 (addr %h)", addr);
        end
        rd  = cur_prdata;
        err = cur_pslverr;
        @(negedge clk);
        p1 = cur_pulse; f1 = cur_flat;
        psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
        @(negedge clk);
        p2 = cur_pulse; f2 = cur_flat;
    endtask

    typedef struct {
        bit          dut;
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        bit          chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int unsigned exp_waits;
        logic [15:0] exp_pulse;
    } vec_t;

    vec_t vecs [19];

    initial begin
        logic [31:0]  rd;
        logic         err;
        int unsigned  waits;
        logic [15:0]  p1, p2;
        logic [511:0] f1, f2;

        //         dut   wr    addr   wdata          strb  chk   exp_rd         err   waits pulse
        vecs[0]  = '{1'b0, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 1'b0, 32'h00000000, 1'b0, 0, 16'h0002};
        vecs[1]  = '{1'b0, 1'b0, 8'h04, 32'h00000000, 4'h0, 1'b1, 32'hDEADBEEF, 1'b0, 0, 16'h0000};
        vecs[2]  = '{1'b0, 1'b1, 8'h04, 32'h11223344, 4'h5, 1'b0, 32'h00000000, 1'b0, 0, 16'h0002};
        vecs[3]  = '{1'b0, 1'b0, 8'h04, 32'h00000000, 4'h0, 1'b1, 32'hDE22BE44, 1'b0, 0, 16'h0000};
        vecs[4]  = '{1'b0, 1'b1, 8'h08, 32'h12345678, 4'hF, 1'b0, 32'h00000000, 1'b1, 0, 16'h0000};
        vecs[5]  = '{1'b0, 1'b0, 8'h08, 32'h00000000, 4'h0, 1'b1, 32'hCAFE0002, 1'b0, 0, 16'h0000};
        vecs[6]  = '{1'b0, 1'b1, 8'h40, 32'h55555555, 4'hF, 1'b0, 32'h00000000, 1'b1, 0, 16'h0000};
        vecs[7]  = '{1'b0, 1'b0, 8'h40, 32'h00000000, 4'h0, 1'b1, 32'h00000000, 1'b1, 0, 16'h0000};
        vecs[8]  = '{1'b0, 1'b0, 8'h05, 32'h00000000, 4'h0, 1'b1, 32'h00000000, 1'b1, 0, 16'h0000};
        vecs[9]  = '{1'b0, 1'b1, 8'h05, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h00000000, 1'b1, 0, 16'h0000};
        vecs[10] = '{1'b0, 1'b0, 8'h04, 32'h00000000, 4'h0, 1'b1, 32'hDE22BE44, 1'b0, 0, 16'h0000};
        vecs[11] = '{1'b0, 1'b1, 8'h00, 32'hAABBCCDD, 4'h0, 1'b0, 32'h00000000, 1'b0, 0, 16'h0001};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 32'h00000000, 4'h0, 1'b1, 32'h00000000, 1'b0, 0, 16'h0000};
        vecs[13] = '{1'b0, 1'b1, 8'h3C, 32'h0F0F0F0F, 4'hF, 1'b0, 32'h00000000, 1'b0, 0, 16'h8000};
        vecs[14] = '{1'b0, 1'b0, 8'h3C, 32'h00000000, 4'h0, 1'b1, 32'h0F0F0F0F, 1'b0, 0, 16'h0000};
        vecs[15] = '{1'b1, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 1'b0, 32'h00000000, 1'b0, 3, 16'h0002};
        vecs[16] = '{1'b1, 1'b0, 8'h04, 32'h00000000, 4'h0, 1'b1, 32'hDEADBEEF, 1'b0, 3, 16'h0000};
        vecs[17] = '{1'b1, 1'b0, 8'h0C, 32'h00000000, 4'h0, 1'b1, 32'h00000000, 1'b0, 3, 16'h0000};
        vecs[18] = '{1'b1, 1'b1, 8'h40, 32'h77777777, 4'hF, 1'b0, 32'h00000000, 1'b1, 3, 16'h0000};

        hw_flat = '0;
        hw_flat[95:64] = 32'hCAFE0002;
        psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h0; pwdata = 32'h0; pstrb = 4'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("reset pready", {31'b0, if0.pready}, 32'h0);
        check("reset pslverr", {31'b0, if0.pslverr}, 32'h0);
        check("reset prdata", if0.prdata, 32'h0);
        check("reset reg_flat", {31'b0, |flat0}, 32'h0);
        check("reset wr_pulse", {16'b0, pulse0}, 32'h0);

        for (int i = 0; i < 19; i++) begin
            xfer(vecs[i].dut, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                 rd, err, waits, p1, p2, f1, f2);
            if (vecs[i].chk_rd) check($sformatf("vec%0d prdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d pslverr", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
            check($sformatf("vec%0d waits", i), waits, vecs[i].exp_waits);
            check($sformatf("vec%0d wr_pulse", i), {16'b0, p1}, {16'b0, vecs[i].exp_pulse});
            check($sformatf("vec%0d pulse drop", i), {16'b0, p2}, 32'h0);
        end

        // Core-side view of stored registers; RO register never stores bus writes
        check("flat0 reg1", flat0[63:32], 32'hDE22BE44);
        check("flat0 reg2", flat0[95:64], 32'h0);
        check("flat1 reg1", flat1[63:32], 32'hDEADBEEF);

        // Self-clearing register: bit visible one cycle only
        xfer(1'b0, 1'b1, 8'h0C, 32'h00000001, 4'hF, rd, err, waits, p1, p2, f1, f2);
        check("sc bit first cycle", {31'b0, f1[96]}, 32'h1);
        check("sc bit next cycle", {31'b0, f2[96]}, 32'h0);
        check("sc pulse", {16'b0, p1}, 32'h0008);

        // Back-to-back: write reg 6 then immediately read it, no idle cycle
        cur = 1'b0;
        @(negedge clk);
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h18;
        pwdata = 32'hA5A5_0606; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        check("b2b write pready", {31'b0, if0.pready}, 32'h1);
        @(negedge clk);
        penable = 1'b0; pwrite = 1'b0;
        check("b2b pulse", {16'b0, pulse0}, 32'h0040);
        @(negedge clk);
        penable = 1'b1;
        check("b2b read pready", {31'b0, if0.pready}, 32'h1);
        check("b2b read prdata", if0.prdata, 32'hA5A50606);
        @(negedge clk);
        psel0 = 1'b0; penable = 1'b0;

        // Abort in wait states: no write, no pulse
        cur = 1'b1;
        @(negedge clk);
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h14;
        pwdata = 32'h12345678; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel1 = 1'b0; penable = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("abort pulse", {16'b0, pulse1}, 32'h0);
        end
        check("abort reg5", flat1[191:160], 32'h0);

        // Reset during wait states of a write
        @(negedge clk);
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10;
        pwdata = 32'hDEADBEEF; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset mid pready", {31'b0, if1.pready}, 32'h0);
        psel1 = 1'b0; penable = 1'b0;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("reset mid reg4", flat1[159:128], 32'h0);
        check("reset mid reg1", flat1[63:32], 32'h0);
        xfer(1'b1, 1'b0, 8'h10, 32'h0, 4'h0, rd, err, waits, p1, p2, f1, f2);
        check("reset mid read reg4", rd, 32'h0);
        check("reset mid read err", {31'b0, err}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
